// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS-lite core.
// Freezes on data-memory wait, bubbles on load-use, flushes on taken branch.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_memread,
    input  logic [4:0]       ex_wn,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q;

    logic mem_busy;
    logic load_use;
    logic rs_hit;
    logic rt_hit;
    logic freeze;
    logic lu_sel;
    logic br_sel;

    assign mem_busy = (mem_memread | mem_memwrite) & ~mem_ready;

    assign rs_hit   = (ex_wn == id_rs);
    assign rt_hit   = id_uses_rt & (ex_wn == id_rt);
    assign load_use = ex_memread & (ex_wn != 5'd0) & (rs_hit | rt_hit);

    // Mutually exclusive selects so the decoder below is truly one-hot.
    assign freeze = (state_q == HALT) | mem_busy;
    assign lu_sel = ~freeze & load_use;
    assign br_sel = ~freeze & ~load_use & id_branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    wait_d = 8'd1;
                    if (MAX_WAIT == 1) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // Ready or withdrawn access both release the wait.
                if (!mem_busy) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        unique case (1'b1)
            freeze: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
            lu_sel: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            br_sel: begin
                ifid_flush = 1'b1;
            end
            default: begin
                pc_en = 1'b1;
            end
        endcase
    end

    // Halt cycles are not counted; the counter sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q != HALT) && !pc_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl.
// Two instances share stimulus: 16-bit and 4-bit stall counters.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 8;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       ex_mr;
        logic [4:0] ex_wn;
        logic       m_rd;
        logic       m_wr;
        logic       m_rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_wn;
    logic id_uses_rt, id_branch_taken, ex_memread;
    logic mem_memread, mem_memwrite, mem_ready;

    logic pc_en, ifid_en, ifid_flush, idex_en;
    logic idex_bubble, exmem_en, memwb_bubble, mem_timeout;
    logic [15:0] stall_cnt;

    logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en;
    logic s_idex_bubble, s_exmem_en, s_memwb_bubble, s_mem_timeout;
    logic [3:0] s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int m_wait;
    bit m_halt;
    bit m_to;
    int m_cnt;
    int m_cnt4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken),
        .ex_memread(ex_memread), .ex_wn(ex_wn),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken),
        .ex_memread(ex_memread), .ex_wn(ex_wn),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_ready(mem_ready),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_en(s_idex_en), .idex_bubble(s_idex_bubble),
        .exmem_en(s_exmem_en), .memwb_bubble(s_memwb_bubble),
        .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_en memwb_bubble
    function automatic logic [6:0] model_ctrl(input stim_t s, input bit halted);
        bit busy, lu;
        busy = (s.m_rd || s.m_wr) && !s.m_rdy;
        lu = s.ex_mr && (s.ex_wn != 0) &&
             ((s.ex_wn == s.rs) || (s.uses_rt && (s.ex_wn == s.rt)));
        if (halted || busy) return 7'b0000001;
        if (lu)             return 7'b0001110;
        if (s.br)           return 7'b1111010;
        return 7'b1101010;
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_halt = 0;
        m_to   = 0;
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    task automatic cycle(input stim_t s);
        logic [6:0] e;
        bit busy;
        @(negedge clk);
        rst             = s.rst;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rt      = s.uses_rt;
        id_branch_taken = s.br;
        ex_memread      = s.ex_mr;
        ex_wn           = s.ex_wn;
        mem_memread     = s.m_rd;
        mem_memwrite    = s.m_wr;
        mem_ready       = s.m_rdy;
        #1;
        if (s.rst) model_reset();
        e = model_ctrl(s, m_halt);
        check("ctrl", {pc_en, ifid_en, ifid_flush, idex_en,
                       idex_bubble, exmem_en, memwb_bubble}, 32'(e));
        check("ctrl4", {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en,
                        s_idex_bubble, s_exmem_en, s_memwb_bubble}, 32'(e));
        check("timeout", 32'(mem_timeout), 32'(m_to));
        check("timeout4", 32'(s_mem_timeout), 32'(m_to));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        check("stall_cnt4", 32'(s_stall_cnt), 32'(m_cnt4));
        if (!s.rst && !m_halt) begin
            if (!e[6]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            busy = (s.m_rd || s.m_wr) && !s.m_rdy;
            if (busy) begin
                m_wait++;
                if (m_wait >= MAX_WAIT) begin
                    m_halt = 1;
                    m_to   = 1;
                end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.m_rdy = 1'b1;
        return s;
    endfunction

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        cycle(s);
        cycle(s);
        s.rst = 1'b0;
        cycle(s);
    endtask

    initial begin
        stim_t s;
        rst = 1'b1;
        {id_rs, id_rt, ex_wn} = '0;
        {id_uses_rt, id_branch_taken, ex_memread} = '0;
        {mem_memread, mem_memwrite} = '0;
        mem_ready = 1'b1;
        model_reset();

        do_reset();
        check("reset_cnt", 32'(stall_cnt), 32'd0);

        // Load-use on rs: exactly one stall cycle.
        s = idle(); s.ex_mr = 1; s.ex_wn = 5; s.rs = 5;
        cycle(s);
        check("lu_rs_bubble", 32'(idex_bubble), 32'd1);
        s = idle();
        cycle(s);
        check("lu_rs_cnt", 32'(stall_cnt), 32'd1);
        check("lu_rs_pc", 32'(pc_en), 32'd1);

        // Destination $0 never stalls.
        s = idle(); s.ex_mr = 1; s.ex_wn = 0; s.rs = 0;
        cycle(s);
        check("wn0_pc", 32'(pc_en), 32'd1);

        // Load-use on rt depends on id_uses_rt.
        s = idle(); s.ex_mr = 1; s.ex_wn = 7; s.rt = 7; s.rs = 3;
        cycle(s);
        check("rt_unused_pc", 32'(pc_en), 32'd1);
        s.uses_rt = 1;
        cycle(s);
        check("rt_used_pc", 32'(pc_en), 32'd0);
        s = idle();
        cycle(s);
        check("rt_cnt", 32'(stall_cnt), 32'd2);

        // Three wait states then ready.
        do_reset();
        s = idle(); s.m_rd = 1; s.m_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(s);
            check("wait_memwb", 32'(memwb_bubble), 32'd1);
        end
        s.m_rdy = 1;
        cycle(s);
        check("wait_release_pc", 32'(pc_en), 32'd1);
        check("wait_cnt3", 32'(stall_cnt), 32'd3);
        check("wait_to", 32'(mem_timeout), 32'd0);

        // Timeout on a write held not-ready.
        s = idle(); s.m_wr = 1; s.m_rdy = 0;
        for (int i = 0; i < MAX_WAIT; i++) cycle(s);
        check("to_before", 32'(mem_timeout), 32'd0);
        s = idle();
        for (int i = 0; i < 4; i++) begin
            cycle(s);
            check("to_set", 32'(mem_timeout), 32'd1);
            check("to_freeze", 32'(exmem_en), 32'd0);
        end
        check("to_cnt", 32'(stall_cnt), 32'd11);

        // Async reset clears the error with no clock edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_to", 32'(mem_timeout), 32'd0);
        check("async_pc", 32'(pc_en), 32'd1);
        model_reset();
        s = idle(); s.rst = 1;
        cycle(s);
        s.rst = 0;
        cycle(s);

        // Branch together with load-use: stall first, flush next.
        s = idle(); s.br = 1; s.ex_mr = 1; s.ex_wn = 9; s.rs = 9;
        cycle(s);
        check("brlu_flush", 32'(ifid_flush), 32'd0);
        check("brlu_pc", 32'(pc_en), 32'd0);
        s.ex_mr = 0;
        cycle(s);
        check("br_flush", 32'(ifid_flush), 32'd1);
        check("br_pc", 32'(pc_en), 32'd1);

        // Saturation of the 4-bit counter.
        do_reset();
        s = idle(); s.ex_mr = 1; s.ex_wn = 4; s.rs = 4;
        for (int i = 0; i < 20; i++) cycle(s);
        s = idle();
        cycle(s);
        check("sat4", 32'(s_stall_cnt), 32'd15);
        check("sat16", 32'(stall_cnt), 32'd20);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s.rst     = m_halt ? ($urandom_range(0, 9) == 0)
                               : ($urandom_range(0, 199) == 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.uses_rt = 1'($urandom);
            s.br      = ($urandom_range(0, 3) == 0);
            s.ex_mr   = 1'($urandom);
            s.ex_wn   = 5'($urandom_range(0, 3));
            s.m_rd    = ($urandom_range(0, 2) == 0);
            s.m_wr    = ($urandom_range(0, 4) == 0);
            s.m_rdy   = ($urandom_range(0, 3) != 0);
            cycle(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
